// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the instruction/data memory bus arbiter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// rtl/mem_bus_arbiter_grant_sel.sv - combinational grant select (fixed data priority, or
// round-robin when ARB_ROUND_ROBIN_EN is defined)
module bus_grant_sel
    import mem_bus_pkg::*;
(
    input  logic i_inst_req,
    input  logic i_data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_grant,
`endif
    output logic o_any,
    output logic o_grant
);

    always_comb begin
        o_any   = i_inst_req | i_data_req;
        o_grant = OWNER_INST;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_inst_req && i_data_req) begin
            // Contention: favour whichever side lost last time.
            if (i_last_grant == OWNER_DATA) begin
                o_grant = OWNER_INST;
            end else begin
                o_grant = OWNER_DATA;
            end
        end else if (i_data_req) begin
            o_grant = OWNER_DATA;
        end
`else
        if (i_data_req) begin
            o_grant = OWNER_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter of IF and MEM ports onto one SRAM-like bus
// Optional macro: ARB_ROUND_ROBIN_EN selects round-robin grant under contention.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  arb_busy
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    owner_t              r_owner;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_any;
    logic                w_grant;
    logic                w_addr_hs;
    logic                w_data_hs;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWNER_INST;
        end else if (r_state == ST_IDLE && w_any) begin
            r_last_grant <= owner_t'(w_grant);
        end
    end
`endif

    bus_grant_sel u_grant_sel (
        .i_inst_req   (inst_req),
        .i_data_req   (data_req),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .o_any        (w_any),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWNER_INST;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any) begin
                r_owner <= owner_t'(w_grant);
                if (w_grant == OWNER_DATA) begin
                    r_wr    <= data_wr;
                    r_size  <= data_size;
                    r_wstrb <= data_wstrb;
                    r_addr  <= data_addr;
                    r_wdata <= data_wdata;
                end else begin
                    // Fetches are always word reads with no write payload.
                    r_wr    <= 1'b0;
                    r_size  <= SIZE_WORD;
                    r_wstrb <= '0;
                    r_addr  <= inst_addr;
                    r_wdata <= '0;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_hs    = 1'b0;
        w_data_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    w_addr_hs = 1'b1;
                    if (m_data_ok) begin
                        w_data_hs    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    w_data_hs    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = w_addr_hs && (r_owner == OWNER_INST);
        data_addr_ok = w_addr_hs && (r_owner == OWNER_DATA);
        inst_data_ok = w_data_hs && (r_owner == OWNER_INST);
        data_data_ok = w_data_hs && (r_owner == OWNER_DATA);
        inst_rdata   = inst_data_ok ? m_rdata : '0;
        data_rdata   = data_data_ok ? m_rdata : '0;
    end

    assign m_req    = (r_state == ST_ADDR);
    assign m_wr     = r_wr;
    assign m_size   = r_size;
    assign m_wstrb  = r_wstrb;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign arb_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam logic [31:0] GARB = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata = GARB;
    logic        arb_busy;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .arb_busy     (arb_busy)
    );

    typedef struct packed {
        logic        iaok;
        logic        idok;
        logic        daok;
        logic        ddok;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic iaok, input logic idok, input logic daok,
                                input logic ddok, input logic [31:0] ird, input logic [31:0] drd);
        obs_t o;
        o.iaok = iaok; o.idok = idok; o.daok = daok; o.ddok = ddok;
        o.irdata = ird; o.drdata = drd;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake cycle must match the next queued expectation.
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        got = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata};
        if (got.iaok || got.idok || got.daok || got.ddok) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_handshake: got %h expected none (t=%0t)", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("handshake", 80'(got), 80'(e));
            end
        end else begin
            check("rdata_unqualified", 80'({inst_rdata, data_rdata}), 80'd0);
        end
    end

    task automatic issue(input logic is_data, input logic wr, input logic [1:0] size,
                         input logic [3:0] wstrb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int aw, input int dw);
        logic        xwr;
        logic [1:0]  xsize;
        logic [3:0]  xstrb;
        logic [31:0] xwd;
        xwr   = is_data ? wr : 1'b0;
        xsize = is_data ? size : 2'd2;
        xstrb = is_data ? wstrb : 4'd0;
        xwd   = is_data ? wdata : 32'd0;
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_size = size;
            data_wstrb = wstrb; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        tick();
        for (int c = 0; c <= aw; c++) begin
            check("m_req_addr_phase", 80'(m_req), 80'd1);
            check("m_addr", 80'(m_addr), 80'(addr));
            check("m_wr", 80'(m_wr), 80'(xwr));
            check("m_size", 80'(m_size), 80'(xsize));
            check("m_wstrb", 80'(m_wstrb), 80'(xstrb));
            check("m_wdata", 80'(m_wdata), 80'(xwd));
            if (c < aw) tick();
        end
        m_addr_ok = 1'b1;
        if (dw == 0) begin
            m_data_ok = 1'b1;
            m_rdata   = rdata;
            exp_q.push_back(is_data ? mk(0, 0, 1, 1, 32'd0, rdata) : mk(1, 1, 0, 0, rdata, 32'd0));
        end else begin
            exp_q.push_back(is_data ? mk(0, 0, 1, 0, 32'd0, 32'd0) : mk(1, 0, 0, 0, 32'd0, 32'd0));
        end
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = GARB;
        data_req = 1'b0; inst_req = 1'b0;
        if (dw > 0) begin
            for (int c = 1; c < dw; c++) begin
                check("m_req_data_phase", 80'(m_req), 80'd0);
                check("m_wdata_stable", 80'(m_wdata), 80'(xwd));
                check("busy_data_phase", 80'(arb_busy), 80'd1);
                tick();
            end
            check("m_req_data_phase", 80'(m_req), 80'd0);
            m_data_ok = 1'b1;
            m_rdata   = rdata;
            exp_q.push_back(is_data ? mk(0, 0, 0, 1, 32'd0, rdata) : mk(0, 1, 0, 0, rdata, 32'd0));
            tick();
            m_data_ok = 1'b0; m_rdata = GARB;
        end
        check("idle_after_txn", 80'(arb_busy), 80'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_addr;
        logic        exp_data;
        #2;
        check("reset_outputs", 80'({m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
              inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
              inst_rdata, data_rdata, arb_busy}), 80'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;

        // Contention: both requests held for four zero-wait transactions.
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_addr = 32'h2000_0000;
        data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'd0; data_wdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (k % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            exp_addr = exp_data ? 32'h2000_0000 : 32'h0000_0100;
            check("arb_m_req", 80'(m_req), 80'd1);
            check("arb_grant_addr", 80'(m_addr), 80'(exp_addr));
            m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_0000 + k;
            exp_q.push_back(exp_data ? mk(0, 0, 1, 1, 32'd0, 32'h1111_0000 + k)
                                     : mk(1, 1, 0, 0, 32'h1111_0000 + k, 32'd0));
            tick();
            m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = GARB;
            if (k == 3) begin
                inst_req = 1'b0; data_req = 1'b0;
            end
        end
        tick();
        check("arb_idle", 80'(arb_busy), 80'd0);

        // Single zero-wait load.
        issue(1'b1, 1'b0, 2'd2, 4'b0000, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0);

        // Byte store: two address wait cycles, completion three cycles after acceptance.
        issue(1'b1, 1'b1, 2'd0, 4'b1000, 32'h1000_0003, 32'h5A5A_5A5A, 32'h0000_0000, 2, 3);

        // Stray completion in IDLE is ignored.
        m_data_ok = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_data_ok = 1'b0; m_rdata = GARB;
        check("stray_idle", 80'(arb_busy), 80'd0);
        tick();
        check("stray_idle_m_req", 80'(m_req), 80'd0);

        // Data load completes while a fetch is waiting; fetch wins the next IDLE.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0010;
        tick();
        m_addr_ok = 1'b1;
        exp_q.push_back(mk(0, 0, 1, 0, 32'd0, 32'd0));
        tick();
        m_addr_ok = 1'b0; data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        m_data_ok = 1'b1; m_rdata = 32'h600D_F00D;
        exp_q.push_back(mk(0, 0, 0, 1, 32'd0, 32'h600D_F00D));
        tick();
        m_data_ok = 1'b0; m_rdata = GARB;
        check("handoff_idle", 80'(arb_busy), 80'd0);
        tick();
        check("handoff_inst_addr", 80'(m_addr), 80'h0000_0200);
        check("handoff_m_req", 80'(m_req), 80'd1);
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1357_9BDF;
        exp_q.push_back(mk(1, 1, 0, 0, 32'h1357_9BDF, 32'd0));
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = GARB; inst_req = 1'b0;

        // Reset while an instruction fetch sits in DATA.
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_0300;
        tick();
        m_addr_ok = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 32'd0, 32'd0));
        tick();
        m_addr_ok = 1'b0; inst_req = 1'b0;
        check("busy_before_reset", 80'(arb_busy), 80'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 80'({m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
              inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
              inst_rdata, data_rdata, arb_busy}), 80'd0);
        m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
        #1;
        check("reset_no_inst_data_ok", 80'({inst_data_ok, inst_rdata}), 80'd0);
        tick();
        rst = 1'b0; m_data_ok = 1'b0; m_rdata = GARB;
        tick();
        issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h0000_0300, 32'd0, 32'hA5A5_0001, 1, 1);

        tick();
        tick();
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
